// File: rtl/apple_1_pia.sv
// apple_1_pia: Apple-1 keyboard/display PIA sitting on the 6502 bus next to the
// WozMon ROM. It has four registers (KBD, KBDCR, DSP, DSPCR) at BASE_ADDR+0..3.
// Read data is registered, so it returns one clock after the address, like the ROM.
//
// Host handshakes: both channels use valid/ready. A transfer happens on a rising
// clock edge where valid and ready are both 1. A source holds valid and data stable
// until that transfer. Neither ready depends combinationally on the other side's valid.
//
// Optional feature: define APPLE1_PIA_UPPERCASE_EN to fold a..z to A..Z at push time.
module apple_1_pia #(
  parameter logic [15:0] BASE_ADDR = 16'hD010,
  parameter int          KBD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] AB,
  input  logic [7:0]  DO,
  input  logic        WE,
  output logic [7:0]  pia_dout,
  output logic        pia_sel,
  input  logic [6:0]  kbd_data,
  input  logic        kbd_valid,
  output logic        kbd_ready,
  output logic [6:0]  dsp_data,
  output logic        dsp_valid,
  input  logic        dsp_ready
);

  localparam int PW = (KBD_DEPTH > 1) ? $clog2(KBD_DEPTH) : 1;

  // CPU-side registers
  logic [7:0]    r_pia_dout;
  logic          r_pia_sel;
  logic [6:0]    r_kbdcr;
  logic [6:0]    r_dspcr;
  logic [7:0]    r_ddr;
  logic [6:0]    r_kbd_last;
  logic [6:0]    r_dsp_data;
  logic          r_dsp_valid;

  // keyboard FIFO
  logic [6:0]    r_mem [KBD_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;

  logic          w_hit;
  logic          w_rd;
  logic          w_wr;
  logic [1:0]    w_off;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [6:0]    w_head;
  logic [6:0]    w_kbd_in;
  logic [7:0]    w_rd_val;
  logic          w_dsp_accept;
  logic          w_dsp_done;

  assign w_hit   = (AB[15:2] == BASE_ADDR[15:2]);
  assign w_rd    = w_hit & ~WE;
  assign w_wr    = w_hit & WE;
  assign w_off   = AB[1:0];

  // Depth is a power of two, so "full" is exactly the count MSB.
  assign w_empty = (r_count == '0);
  assign w_full  = r_count[PW];
  assign w_head  = r_mem[r_rptr];

  assign w_push  = kbd_valid & ~w_full;
  assign w_pop   = w_rd & (w_off == 2'd0) & ~w_empty;

  // A display write is taken only in display mode and only when nothing is pending.
  assign w_dsp_accept = w_wr & (w_off == 2'd2) & r_dspcr[2] & ~r_dsp_valid;
  assign w_dsp_done   = r_dsp_valid & dsp_ready;

`ifdef APPLE1_PIA_UPPERCASE_EN
  // Fold lower-case ASCII to upper case before it enters the FIFO.
  always_comb begin
    w_kbd_in = kbd_data;
    if ((kbd_data >= 7'h61) && (kbd_data <= 7'h7A)) begin
      w_kbd_in = kbd_data - 7'h20;
    end
  end
`else
  assign w_kbd_in = kbd_data;
`endif

  // Register read mux; values reflect state before this cycle's side effects.
  always_comb begin
    w_rd_val = 8'h00;
    case (w_off)
      2'd0: w_rd_val = {1'b1, (w_empty ? r_kbd_last : w_head)};
      2'd1: w_rd_val = {~w_empty, r_kbdcr};
      2'd2: w_rd_val = r_dspcr[2] ? {r_dsp_valid, r_dsp_data} : r_ddr;
      2'd3: w_rd_val = {1'b0, r_dspcr};
      default: w_rd_val = 8'h00;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_kbd_in;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered read response: pia_sel marks a read hit from the previous cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pia_sel  <= 1'b0;
      r_pia_dout <= 8'h00;
    end else begin
      r_pia_sel <= w_rd;
      if (w_rd) begin
        r_pia_dout <= w_rd_val;
      end
    end
  end

  // Control registers, DDR and the last popped keyboard character.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kbdcr    <= 7'h00;
      r_dspcr    <= 7'h00;
      r_ddr      <= 8'h00;
      r_kbd_last <= 7'h00;
    end else begin
      if (w_pop) begin
        r_kbd_last <= w_head;
      end
      if (w_wr) begin
        case (w_off)
          2'd1: r_kbdcr <= DO[6:0];
          2'd2: if (!r_dspcr[2]) r_ddr <= DO;
          2'd3: r_dspcr <= DO[6:0];
          default: ;
        endcase
      end
    end
  end

  // Display output channel: a write loads the char, the host handshake clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dsp_valid <= 1'b0;
      r_dsp_data  <= 7'h00;
    end else begin
      if (w_dsp_accept) begin
        r_dsp_valid <= 1'b1;
        r_dsp_data  <= DO[6:0];
      end else if (w_dsp_done) begin
        r_dsp_valid <= 1'b0;
      end
    end
  end

  assign pia_dout  = r_pia_dout;
  assign pia_sel   = r_pia_sel;
  assign kbd_ready = ~w_full;
  assign dsp_data  = r_dsp_data;
  assign dsp_valid = r_dsp_valid;

endmodule

// File: tb/tb_apple_1_pia.sv
// tb_apple_1_pia: bench for apple_1_pia. Stimulus tasks update a queue-based
// behavioural model and push expected read data / display chars into queues;
// negedge monitors pop and compare whenever the DUT presents a response.
module tb_apple_1_pia;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] AB = 16'h0000;
  logic [7:0]  DO = 8'h00;
  logic        WE = 1'b0;
  logic [7:0]  pia_dout;
  logic        pia_sel;
  logic [6:0]  kbd_data = 7'h00;
  logic        kbd_valid = 1'b0;
  logic        kbd_ready;
  logic [6:0]  dsp_data;
  logic        dsp_valid;
  logic        dsp_ready = 1'b0;

  int n_chk = 0;
  int n_bad = 0;

  // scoreboards
  logic [7:0] exp_q[$];
  logic [6:0] dsp_q[$];

  // behavioural model state
  logic [6:0] m_fifo[$];
  logic [6:0] m_last;
  logic [6:0] m_kbdcr;
  logic [6:0] m_dspcr;
  logic [7:0] m_ddr;
  logic       m_busy;
  logic [6:0] m_dspdata;
  logic       m_sel_prev;

  apple_1_pia #(.BASE_ADDR(16'hD010), .KBD_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .AB(AB), .DO(DO), .WE(WE),
    .pia_dout(pia_dout), .pia_sel(pia_sel),
    .kbd_data(kbd_data), .kbd_valid(kbd_valid), .kbd_ready(kbd_ready),
    .dsp_data(dsp_data), .dsp_valid(dsp_valid), .dsp_ready(dsp_ready)
  );

  // clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] fold(input logic [6:0] c);
`ifdef APPLE1_PIA_UPPERCASE_EN
    if (c >= 7'h61 && c <= 7'h7A) return c - 7'h20;
`endif
    return c;
  endfunction

  task automatic model_clear();
    m_fifo.delete();
    m_last = 7'h00; m_kbdcr = 7'h00; m_dspcr = 7'h00; m_ddr = 8'h00;
    m_busy = 1'b0; m_dspdata = 7'h00; m_sel_prev = 1'b0;
  endtask

  // One bus/host cycle. Entered and left at posedge+1.
  task automatic cyc(input logic [15:0] ab, input logic we, input logic [7:0] d,
                     input logic kv, input logic [6:0] kd, input logic dr,
                     output logic acc);
    logic       hit, rd, wr, rdy, busy0;
    logic [1:0] off;
    logic [7:0] v;
    check("pia_sel", pia_sel, m_sel_prev);
    AB = ab; WE = we; DO = d; kbd_valid = kv; kbd_data = kd; dsp_ready = dr;
    rdy = (m_fifo.size() < DEPTH);
    check("kbd_ready", kbd_ready, rdy);
    check("dsp_valid", dsp_valid, m_busy);
    if (m_busy) check("dsp_data_hold", dsp_data, m_dspdata);
    hit = (ab >= 16'hD010) && (ab <= 16'hD013);
    rd = hit && !we;
    wr = hit && we;
    off = ab[1:0];
    busy0 = m_busy;
    if (rd) begin
      case (off)
        2'd0: v = {1'b1, (m_fifo.size() != 0) ? m_fifo[0] : m_last};
        2'd1: v = {m_fifo.size() != 0, m_kbdcr};
        2'd2: v = m_dspcr[2] ? {m_busy, m_dspdata} : m_ddr;
        default: v = {1'b0, m_dspcr};
      endcase
      exp_q.push_back(v);
      if (off == 2'd0 && m_fifo.size() != 0) m_last = m_fifo.pop_front();
    end
    acc = kv && rdy;
    if (acc) m_fifo.push_back(fold(kd));
    if (wr) begin
      case (off)
        2'd1: m_kbdcr = d[6:0];
        2'd3: m_dspcr = d[6:0];
        2'd2: begin
          if (!m_dspcr[2]) m_ddr = d;
          else if (!busy0) begin
            m_busy = 1'b1; m_dspdata = d[6:0]; dsp_q.push_back(d[6:0]);
          end
        end
        default: ;
      endcase
    end
    if (busy0 && dr) m_busy = 1'b0;
    m_sel_prev = rd;
    @(posedge clk); #1;
  endtask

  task automatic rd_reg(input logic [15:0] ab);
    logic a;
    cyc(ab, 1'b0, 8'h00, 1'b0, 7'h00, 1'b0, a);
  endtask

  task automatic wr_reg(input logic [15:0] ab, input logic [7:0] d);
    logic a;
    cyc(ab, 1'b1, d, 1'b0, 7'h00, 1'b0, a);
  endtask

  task automatic idle(input logic dr);
    logic a;
    cyc(16'h0000, 1'b0, 8'h00, 1'b0, 7'h00, dr, a);
  endtask

  task automatic push(input logic [6:0] c);
    logic a;
    cyc(16'h0000, 1'b0, 8'h00, 1'b1, c, 1'b0, a);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic mid_reset();
    idle(1'b0);
    #2 reset = 1'b1;
    #1;
    check("rst_kbd_ready", kbd_ready, 1'b1);
    check("rst_pia_sel", pia_sel, 1'b0);
    check("rst_dsp_valid", dsp_valid, 1'b0);
    check("rst_dsp_data", dsp_data, 7'h00);
    model_clear();
    dsp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Monitor: compares read responses and display transfers against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (pia_sel) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_bad++;
          $display("FAIL pia_read: unexpected pia_sel, got dout=%0h want none", pia_dout);
        end else begin
          check("pia_dout", pia_dout, exp_q.pop_front());
        end
      end
      if (dsp_valid && dsp_ready) begin
        if (dsp_q.size() == 0) begin
          n_chk++; n_bad++;
          $display("FAIL dsp_xfer: unexpected char %0h want none", dsp_data);
        end else begin
          check("dsp_xfer", dsp_data, dsp_q.pop_front());
        end
      end
    end
  end

  // Main stimulus sequence
  initial begin
    logic       acc;
    logic       pv;
    logic [6:0] pd;
    logic [6:0] str [5];
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    check("init_pia_dout", pia_dout, 8'h00);
    check("init_pia_sel", pia_sel, 1'b0);
    check("init_kbd_ready", kbd_ready, 1'b1);
    check("init_dsp_valid", dsp_valid, 1'b0);
    check("init_dsp_data", dsp_data, 7'h00);
    rd_reg(16'hD011);

    // WozMon init: DDR store, then control registers
    wr_reg(16'hD012, 8'h7F);
    rd_reg(16'hD012);
    wr_reg(16'hD011, 8'hA7);
    wr_reg(16'hD013, 8'hA7);
    rd_reg(16'hD012);
    rd_reg(16'hD013);
    rd_reg(16'hD011);

    // single key
    push(7'h41);
    rd_reg(16'hD011);
    rd_reg(16'hD010);
    rd_reg(16'hD011);
    rd_reg(16'hD010);

    // fill past depth, pop one while the 5th is held
    str[0] = 7'h48; str[1] = 7'h45; str[2] = 7'h4C; str[3] = 7'h50; str[4] = 7'h21;
    for (int i = 0; i < 4; i++) push(str[i]);
    cyc(16'h0000, 1'b0, 8'h00, 1'b1, str[4], 1'b0, acc);
    check("full_held", acc, 1'b0);
    cyc(16'hD010, 1'b0, 8'h00, 1'b1, str[4], 1'b0, acc);
    cyc(16'h0000, 1'b0, 8'h00, 1'b1, str[4], 1'b0, acc);
    check("fifth_taken", acc, 1'b1);
    for (int i = 0; i < 5; i++) rd_reg(16'hD010);
    rd_reg(16'hD011);

    // display channel
    wr_reg(16'hD012, 8'h8D);
    rd_reg(16'hD012);
    wr_reg(16'hD012, 8'hC1);
    rd_reg(16'hD012);
    idle(1'b1);
    rd_reg(16'hD012);

    // case folding
    push(7'h61);
    rd_reg(16'hD010);
    push(7'h7A);
    push(7'h5B);
    rd_reg(16'hD010);
    rd_reg(16'hD010);

    // reset with FIFO populated and a display char pending
    push(7'h31);
    push(7'h32);
    wr_reg(16'hD012, 8'hB3);
    mid_reset();
    rd_reg(16'hD011);
    rd_reg(16'hD010);

    // randomized traffic
    pv = 1'b0; pd = 7'h00;
    for (int n = 0; n < 4000; n++) begin
      logic [15:0] ab;
      logic        we;
      logic [7:0]  d;
      if (!pv && $urandom_range(0, 2) == 0) begin
        pv = 1'b1;
        pd = 7'($urandom_range(0, 127));
      end
      if ($urandom_range(0, 9) < 8) ab = 16'hD010 + 16'($urandom_range(0, 3));
      else ab = 16'($urandom_range(0, 65535));
      we = ($urandom_range(0, 2) == 0);
      d = 8'($urandom_range(0, 255));
      cyc(ab, we, d, pv, pd, ($urandom_range(0, 3) == 0), acc);
      if (acc) pv = 1'b0;
      if (n == 2000) mid_reset();
    end

    idle(1'b0);
    idle(1'b0);
    check("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
